ccp_write_arbiter: RTL and testbench



---
 rtl/ccp_write_arbiter_pkg.sv | 16 +
 rtl/ccp_rr_pick.sv | 24 ++
 rtl/ccp_write_arbiter.sv | 99 +++++++++
 tb/tb_ccp_write_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ccp_write_arbiter_pkg.sv
// Shared definitions for the CCP write arbiter: FSM encodings, requester IDs and
// the default transaction timeout.
package ccp_write_arbiter_pkg;

  typedef enum logic [1:0] {
    CcpIdle  = 2'd0,
    CcpGrant = 2'd1,
    CcpWait  = 2'd2
  } ccpState_e;

  localparam logic CcpReqA = 1'b0;
  localparam logic CcpReqB = 1'b1;

  localparam int unsigned CcpDefaultTimeout = 16;

endpackage

// File: rtl/ccp_rr_pick.sv
// Combinational 2-way round-robin picker: the sole requester wins, and on a tie
// the requester that was not granted last time wins.
module ccp_rr_pick
  import ccp_write_arbiter_pkg::*;
(
  input  logic pendingA,
  input  logic pendingB,
  input  logic lastGrant,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid = pendingA | pendingB;
    if (pendingA && pendingB) begin
      winner = (lastGrant == CcpReqA) ? CcpReqB : CcpReqA;
    end else if (pendingB) begin
      winner = CcpReqB;
    end else begin
      winner = CcpReqA;
    end
  end

endmodule

// File: rtl/ccp_write_arbiter.sv
// Two-requester round-robin write arbiter for the shared CCP resource port; holds
// the resource until done or a forced release after TIMEOUT cycles of waiting.
module ccp_write_arbiter
  import ccp_write_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = CcpDefaultTimeout
) (
  input  logic clk,
  input  logic rst,
  input  logic readySignal,
  input  logic doneSignal,
  input  logic writeA,
  input  logic writeB,
  output logic signalA,
  output logic signalB,
  output logic busy,
  output logic pendingA,
  output logic pendingB,
  output logic timeoutErr
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  ccpState_e       stateQ, stateD;
  logic [CntW-1:0] countQ, countD;
  logic            lastGrantQ, lastGrantD;
  logic            pickValid, pickWinner;
  logic            grantA, grantB, errD;

  ccp_rr_pick uPick (
    .pendingA  (pendingA),
    .pendingB  (pendingB),
    .lastGrant (lastGrantQ),
    .valid     (pickValid),
    .winner    (pickWinner)
  );

  always_comb begin
    stateD     = stateQ;
    countD     = countQ;
    lastGrantD = lastGrantQ;
    grantA     = 1'b0;
    grantB     = 1'b0;
    errD       = 1'b0;
    case (stateQ)
      CcpIdle: begin
        if (pickValid && readySignal) begin
          stateD     = CcpGrant;
          lastGrantD = pickWinner;
          grantA     = (pickWinner == CcpReqA);
          grantB     = (pickWinner == CcpReqB);
        end
      end
      CcpGrant: begin
        stateD = CcpWait;
        countD = '0;
      end
      CcpWait: begin
        // Done takes priority over a timeout landing on the same cycle.
        if (doneSignal) begin
          stateD = CcpIdle;
        end else if (countQ == CntLast) begin
          stateD = CcpIdle;
          errD   = 1'b1;
        end else if (countQ != '1) begin
          countD = countQ + CntW'(1);
        end
      end
      default: stateD = CcpIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= CcpIdle;
      countQ     <= '0;
      lastGrantQ <= CcpReqB;
      pendingA   <= 1'b0;
      pendingB   <= 1'b0;
      signalA    <= 1'b0;
      signalB    <= 1'b0;
      busy       <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      stateQ     <= stateD;
      countQ     <= countD;
      lastGrantQ <= lastGrantD;
      // A new write on the grant edge re-arms the flag as a fresh request.
      pendingA   <= writeA | (pendingA & ~grantA);
      pendingB   <= writeB | (pendingB & ~grantB);
      signalA    <= grantA;
      signalB    <= grantB;
      busy       <= (stateD != CcpIdle);
      timeoutErr <= errD;
    end
  end

endmodule

// File: tb/tb_ccp_write_arbiter.sv
// Bench for ccp_write_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_ccp_write_arbiter;

  localparam int Tout = 4;

  logic clk = 1'b0;
  logic rst, readySignal, doneSignal, writeA, writeB;
  logic signalA, signalB, busy, pendingA, pendingB, timeoutErr;

  int checks = 0;
  int errors = 0;

  ccp_write_arbiter #(.TIMEOUT(Tout)) dut (
    .clk         (clk),
    .rst         (rst),
    .readySignal (readySignal),
    .doneSignal  (doneSignal),
    .writeA      (writeA),
    .writeB      (writeB),
    .signalA     (signalA),
    .signalB     (signalB),
    .busy        (busy),
    .pendingA    (pendingA),
    .pendingB    (pendingB),
    .timeoutErr  (timeoutErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 granting, 2 waiting on the resource.
  bit mPendA, mPendB, mLastB, mOwnerB, mErr;
  int mPhase, mElapsed;

  always begin
    @(posedge clk);
    if (rst) begin
      mPendA = 0; mPendB = 0; mLastB = 1; mOwnerB = 0;
      mPhase = 0; mElapsed = 0; mErr = 0;
    end else begin
      mErr = 0;
      if (mPhase == 0) begin
        if ((mPendA || mPendB) && readySignal) begin
          mOwnerB = (mPendA && mPendB) ? !mLastB : mPendB;
          mLastB  = mOwnerB;
          if (mOwnerB) mPendB = 0;
          else mPendA = 0;
          mPhase = 1;
        end
      end else if (mPhase == 1) begin
        mPhase   = 2;
        mElapsed = 0;
      end else begin
        mElapsed++;
        if (doneSignal) mPhase = 0;
        else if (mElapsed == Tout) begin
          mPhase = 0;
          mErr   = 1;
        end
      end
      if (writeA) mPendA = 1;
      if (writeB) mPendB = 1;
    end
    #1;
    chk("model_signalA", signalA, mPhase == 1 && !mOwnerB);
    chk("model_signalB", signalB, mPhase == 1 && mOwnerB);
    chk("model_busy", busy, mPhase != 0);
    chk("model_pendingA", pendingA, mPendA);
    chk("model_pendingB", pendingB, mPendB);
    chk("model_timeoutErr", timeoutErr, mErr);
    if (signalA && signalB) begin
      errors++;
      $display("FAIL grant_onehot actual=%b%b required=not both", signalA, signalB);
    end
  end

  task automatic pulseReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; readySignal = 1'b0; doneSignal = 1'b0; writeA = 1'b0; writeB = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_signalA", signalA, 1'b0);
    chk("rst_signalB", signalB, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pendingA", pendingA, 1'b0);
    chk("rst_pendingB", pendingB, 1'b0);
    chk("rst_timeoutErr", timeoutErr, 1'b0);
    rst = 1'b0;
    readySignal = 1'b1;

    // Single A request: two-cycle latency, done returns to idle.
    @(negedge clk); writeA = 1'b1;
    @(negedge clk); writeA = 1'b0;
    chk("single_pendA", pendingA, 1'b1);
    chk("single_noGrantYet", signalA, 1'b0);
    @(negedge clk);
    chk("single_grantA", signalA, 1'b1);
    chk("single_busy", busy, 1'b1);
    chk("single_pendCleared", pendingA, 1'b0);
    @(negedge clk);
    chk("single_pulseOnce", signalA, 1'b0);
    chk("single_waitBusy", busy, 1'b1);
    doneSignal = 1'b1;
    @(negedge clk); doneSignal = 1'b0;
    chk("single_idle", busy, 1'b0);

    // Ties: A first out of reset, then B, then A again.
    pulseReset();
    writeA = 1'b1; writeB = 1'b1;
    @(negedge clk); writeA = 1'b0; writeB = 1'b0;
    chk("tie_pendA", pendingA, 1'b1);
    chk("tie_pendB", pendingB, 1'b1);
    @(negedge clk);
    chk("tie1_grantA", signalA, 1'b1);
    chk("tie1_drainA", pendingA, 1'b0);
    chk("tie1_keepB", pendingB, 1'b1);
    @(negedge clk); doneSignal = 1'b1;
    @(negedge clk); doneSignal = 1'b0;
    chk("tie1_idle", busy, 1'b0);
    @(negedge clk);
    chk("tie2_grantB", signalB, 1'b1);
    chk("tie2_drainB", pendingB, 1'b0);
    writeA = 1'b1; writeB = 1'b1;
    @(negedge clk); writeA = 1'b0; writeB = 1'b0; doneSignal = 1'b1;
    @(negedge clk); doneSignal = 1'b0;
    @(negedge clk);
    chk("tie3_grantA", signalA, 1'b1);
    chk("tie3_keepB", pendingB, 1'b1);

    // Not ready for 10 cycles: request held, grant one cycle after ready.
    pulseReset();
    readySignal = 1'b0; writeA = 1'b1;
    @(negedge clk); writeA = 1'b0;
    repeat (10) @(negedge clk);
    chk("notready_pendA", pendingA, 1'b1);
    chk("notready_idle", busy, 1'b0);
    readySignal = 1'b1;
    @(negedge clk);
    chk("notready_grantA", signalA, 1'b1);

    // Timeout: no done for Tout cycles of waiting.
    repeat (Tout) @(negedge clk);
    chk("timeout_lastWait", busy, 1'b1);
    chk("timeout_noErrYet", timeoutErr, 1'b0);
    @(negedge clk);
    chk("timeout_released", busy, 1'b0);
    chk("timeout_err", timeoutErr, 1'b1);
    writeA = 1'b1;
    @(negedge clk); writeA = 1'b0;
    chk("timeout_errPulse", timeoutErr, 1'b0);
    @(negedge clk);
    chk("doneLast_grantA", signalA, 1'b1);
    repeat (Tout) @(negedge clk);
    doneSignal = 1'b1;
    @(negedge clk); doneSignal = 1'b0;
    chk("doneLast_idle", busy, 1'b0);
    chk("doneLast_noErr", timeoutErr, 1'b0);

    // Set/clear collision on the grant edge.
    pulseReset();
    writeA = 1'b1;
    @(negedge clk);
    @(negedge clk); writeA = 1'b0;
    chk("collide_grantA", signalA, 1'b1);
    chk("collide_pendA", pendingA, 1'b1);
    @(negedge clk); doneSignal = 1'b1;
    @(negedge clk); doneSignal = 1'b0;
    @(negedge clk);
    chk("collide_secondA", signalA, 1'b1);

    // Reset while waiting with B pending.
    @(negedge clk); writeB = 1'b1;
    @(negedge clk); writeB = 1'b0;
    chk("midrst_pendB", pendingB, 1'b1);
    chk("midrst_busy", busy, 1'b1);
    pulseReset();
    chk("midrst_signalA", signalA, 1'b0);
    chk("midrst_signalB", signalB, 1'b0);
    chk("midrst_busy0", busy, 1'b0);
    chk("midrst_pendA0", pendingA, 1'b0);
    chk("midrst_pendB0", pendingB, 1'b0);
    chk("midrst_err0", timeoutErr, 1'b0);
    repeat (5) @(negedge clk);
    chk("midrst_noGrantB", signalB, 1'b0);
    chk("midrst_stillIdle", busy, 1'b0);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      writeA      = ($urandom_range(0, 3) == 0);
      writeB      = ($urandom_range(0, 3) == 0);
      readySignal = ($urandom_range(0, 3) != 0);
      doneSignal  = ($urandom_range(0, 4) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 1'b0; writeA = 1'b0; writeB = 1'b0; doneSignal = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
